// File: rtl/cpu_defs.sv
// Shared CPU constants and the next-PC select encoding used by the fetch stage.
package cpu_defs;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0004;
  localparam logic [31:0] NOP_WORD_DEFAULT   = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_BR,
    SEL_JMP,
    SEL_HOLD,
    SEL_SEQ
  } pc_sel_e;

  // Redirect targets are always word addresses.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: exception > branch > jump > stall > sequential.
module next_pc_sel
  import cpu_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exc_req,
  output logic [31:0] next_pc,
  output pc_sel_e     sel,
  output logic        flush
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    next_pc = pc + 32'd4;
    sel     = SEL_SEQ;
    flush   = 1'b0;
    if (exc_req) begin
      next_pc = align_word(EXC_VECTOR);
      sel     = SEL_EXC;
      flush   = 1'b1;
    end else if (branch_taken) begin
      // The EX-stage branch is older than the ID-stage jump, so it wins.
      next_pc = align_word(branch_target);
      sel     = SEL_BR;
      flush   = 1'b1;
    end else if (jump_en) begin
      next_pc = align_word(jump_target);
      sel     = SEL_JMP;
      flush   = 1'b1;
    end else if (stall) begin
      next_pc = pc;
      sel     = SEL_HOLD;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory and loads the IF/ID register.
module instruction_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] next_pc;
  pc_sel_e     sel;
  logic        flush;

  assign imem_addr = pc;

  next_pc_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_pc_sel (
    .pc           (pc),
    .stall        (stall),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .exc_req      (exc_req),
    .next_pc      (next_pc),
    .sel          (sel),
    .flush        (flush)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      pc <= next_pc;
      if (flush) begin
        if_id_instr <= NOP_WORD;
        if_id_pc4   <= 32'd0;
        if_id_valid <= 1'b0;
      end else if (sel != SEL_HOLD) begin
        if_id_instr <= imem_instr;
        if_id_pc4   <= pc + 32'd4;
        if_id_valid <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a combinational instruction memory.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  instruction_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .stall        (stall),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .exc_req      (exc_req),
    .pc           (pc),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .fetch_count  (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    stall         = 1'b0;
    jump_en       = 1'b0;
    jump_target   = 32'd0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    exc_req       = 1'b0;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_count);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".imem_addr"}, imem_addr, e_pc);
    check({tag, ".instr"}, if_id_instr, e_instr);
    check({tag, ".pc4"}, if_id_pc4, e_pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    check({tag, ".count"}, fetch_count, e_count);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[0]   = 32'h2004_0007;
    mem[1]   = 32'hAC04_0004;
    mem[2]   = 32'h1111_1111;
    mem[16]  = 32'h3333_3333;
    mem[32]  = 32'h4444_4444;
    mem[255] = 32'h6666_6666;

    rst_n = 1'b0;
    clear_events();
    #12;
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    // Release away from the edge; first edge captures the word at RESET_PC.
    rst_n = 1'b1;
    step();
    check_ifid("seq1", 32'h4, 32'h2004_0007, 32'h4, 1'b1, 32'd1);
    step();
    check_ifid("seq2", 32'h8, 32'hAC04_0004, 32'h8, 1'b1, 32'd2);

    stall = 1'b1;
    step();
    check_ifid("stall1", 32'h8, 32'hAC04_0004, 32'h8, 1'b1, 32'd2);
    step();
    check_ifid("stall2", 32'h8, 32'hAC04_0004, 32'h8, 1'b1, 32'd2);
    stall = 1'b0;
    step();
    check_ifid("resume", 32'hC, 32'h1111_1111, 32'hC, 1'b1, 32'd3);

    // Branch and jump in the same cycle: branch wins, one flush.
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    jump_en       = 1'b1;
    jump_target   = 32'h80;
    step();
    check_ifid("br_jmp", 32'h40, 32'h0, 32'h0, 1'b0, 32'd3);
    clear_events();
    step();
    check_ifid("br_fetch", 32'h44, 32'h3333_3333, 32'h44, 1'b1, 32'd4);

    // Exception redirect overrides stall.
    exc_req = 1'b1;
    stall   = 1'b1;
    step();
    check_ifid("exc_stall", 32'h8000_0004, 32'h0, 32'h0, 1'b0, 32'd4);
    clear_events();

    // Misaligned branch target is word-aligned.
    branch_taken  = 1'b1;
    branch_target = 32'h43;
    step();
    check_ifid("br_align", 32'h40, 32'h0, 32'h0, 1'b0, 32'd4);
    clear_events();
    step();
    check_ifid("br_align_fetch", 32'h44, 32'h3333_3333, 32'h44, 1'b1, 32'd5);

    // Jump to the top of the address space, then wrap.
    jump_en     = 1'b1;
    jump_target = 32'hFFFF_FFFF;
    step();
    check_ifid("jmp_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd5);
    clear_events();
    step();
    check_ifid("wrap", 32'h0, 32'h6666_6666, 32'h0, 1'b1, 32'd6);

    // Jump with stall still redirects.
    jump_en     = 1'b1;
    jump_target = 32'h80;
    stall       = 1'b1;
    step();
    check_ifid("jmp_stall", 32'h80, 32'h0, 32'h0, 1'b0, 32'd6);
    clear_events();
    step();
    check_ifid("jmp_fetch", 32'h84, 32'h4444_4444, 32'h84, 1'b1, 32'd7);

    // Asynchronous reset between edges, with a redirect pending.
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    #2;
    rst_n = 1'b0;
    #1;
    check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    step();
    check_ifid("held_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
